elastic_pipe_reg: RTL and testbench

- Parametrised, handshake-driven pipeline register. It is the successor to the fixed per-field stage latches between EX/MEM/WB.
- Replaces the global stall_current/stall_next scheme with per-stage valid/ready flow control.
- Includes a 2-entry skid buffer, so in_ready is a registered signal and backpressure never creates a combinational path across the stage.
- One instance carries a whole stage bundle (all fields concatenated into in_data). Flush turns in-flight entries into bubbles.

---
 rtl/elastic_pipe_reg.sv | 101 ++++++++++
 tb/tb_elastic_pipe_reg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register with a 2-entry skid buffer.
// The valid/ready handshake is on both sides, and in_ready is decoded from a register.
// Flush drops every held entry and any payload offered in the same cycle.
module elastic_pipe_reg #(
    parameter int unsigned          WIDTH        = 32,
    parameter logic [WIDTH-1:0]     BUBBLE_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // The state encoding is the number of held entries.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             fire_in, fire_out;

    // Handshake outputs come from the state register only.
    always_comb begin
        out_valid = (state_q != StEmpty);
        in_ready  = (state_q != StFull);
        occupancy = state_q;
        // main_q is forced back to the bubble whenever the stage empties.
        out_data  = main_q;
        fire_in   = in_valid & in_ready;
        fire_out  = out_valid & out_ready;
    end

    // Next-state and data-register updates. Flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = BUBBLE_VALUE;
            skid_d  = BUBBLE_VALUE;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (fire_in) begin
                        state_d = StBusy;
                        main_d  = in_data;
                    end
                end
                StBusy: begin
                    if (fire_in && fire_out) begin
                        main_d = in_data;
                    end else if (fire_in) begin
                        state_d = StFull;
                        skid_d  = in_data;
                    end else if (fire_out) begin
                        state_d = StEmpty;
                        main_d  = BUBBLE_VALUE;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only a release can happen.
                    if (fire_out) begin
                        state_d = StBusy;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VALUE;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = BUBBLE_VALUE;
                    skid_d  = BUBBLE_VALUE;
                end
            endcase
        end
    end

    // State and payload registers with an asynchronous reset to the bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= BUBBLE_VALUE;
            skid_q  <= BUBBLE_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Scoreboard bench for elastic_pipe_reg. It drives inputs on the falling edge and
// samples outputs 1 time unit later.
module tb_elastic_pipe_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    // Wide and narrow builds that use an all-ones bubble
    logic        w_in_valid = 1'b0;
    logic        w_out_ready = 1'b0;
    logic        w1_in_data = 1'b0;
    logic [69:0] w70_in_data = '0;
    logic        w1_in_ready, w1_out_valid, w1_out_data;
    logic [1:0]  w1_occ;
    logic        w70_in_ready, w70_out_valid;
    logic [69:0] w70_out_data;
    logic [1:0]  w70_occ;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    elastic_pipe_reg #(.WIDTH(8), .BUBBLE_VALUE(8'h00)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    elastic_pipe_reg #(.WIDTH(1), .BUBBLE_VALUE(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w1_in_ready), .in_data(w1_in_data),
        .out_valid(w1_out_valid), .out_ready(w_out_ready), .out_data(w1_out_data),
        .occupancy(w1_occ)
    );

    elastic_pipe_reg #(.WIDTH(70), .BUBBLE_VALUE({70{1'b1}})) u_w70 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w70_in_ready), .in_data(w70_in_data),
        .out_valid(w70_out_valid), .out_ready(w_out_ready), .out_data(w70_out_data),
        .occupancy(w70_occ)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, check the outputs against the model, and update the scoreboard.
    task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        logic fi, fo;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        check("occupancy", occupancy, sb_q.size());
        check("out_valid", out_valid, sb_q.size() != 0);
        check("in_ready", in_ready, sb_q.size() < 2);
        if (sb_q.size() == 0) check("bubble", out_data, 8'h00);
        fi = iv & in_ready;
        fo = out_valid & ordy;
        if (fo) begin
            if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
            else check("data", out_data, sb_q.pop_front());
        end
        if (fl) sb_q.delete();
        else if (fi) sb_q.push_back(id);
        @(negedge clk);
    endtask

    initial begin
        // Reset state of all three builds
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_occ", occupancy, 2'd0);
        check("rst_out_data", out_data, 8'h00);
        check("w1_rst_data", w1_out_data, 1'b1);
        check("w70_rst_data", w70_out_data, {70{1'b1}});
        @(negedge clk);
        rst = 1'b0;

        // Wide builds: load zero, drain it, and expect the all-ones bubble again
        w_in_valid = 1'b1; w_out_ready = 1'b1; w1_in_data = 1'b0; w70_in_data = '0;
        @(negedge clk);
        w_in_valid = 1'b0;
        #1;
        check("w1_data", w1_out_data, 1'b0);
        check("w70_data", w70_out_data, 70'd0);
        check("w70_valid", w70_out_valid, 1'b1);
        @(negedge clk);
        #1;
        check("w1_empty_data", w1_out_data, 1'b1);
        check("w70_empty_data", w70_out_data, {70{1'b1}});
        check("w70_empty_valid", w70_out_valid, 1'b0);
        @(negedge clk);

        // Streaming with out_ready held high
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Downstream stall fills the stage, then a drain
        step(1'b1, 8'hA0, 1'b0, 1'b0);
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        #1;
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_occ", occupancy, 2'd2);
        check("stall_head", out_data, 8'hA0);
        step(1'b1, 8'hA2, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b1, 1'b0);
        step(1'b1, 8'hA2, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush while FULL drops the payload offered in the same cycle
        step(1'b1, 8'hB0, 1'b0, 1'b0);
        step(1'b1, 8'hB1, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        #1;
        check("flush_occ", occupancy, 2'd0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_ready", in_ready, 1'b1);
        check("flush_data", out_data, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between clock edges while FULL
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        check("arst_occ", occupancy, 2'd0);
        check("arst_data", out_data, 8'h00);
        #1 rst = 1'b0;
        sb_q.delete();
        @(negedge clk);

        // Random traffic with occasional flushes
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0));
        end
        // Drain whatever is left
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
